// File: rtl/display_scan_controller.sv
// Scans DIGITS common-enable digits through one shared hex decoder, with a
// frame-synchronous shadow->active value commit and a blanking window per slot.
module display_scan_controller #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  LoadValid,
  output logic                  LoadReady,
  input  logic [4*DIGITS-1:0]   LoadData,
  input  logic [DIGITS-1:0]     BlankMask,
  output logic [3:0]            DecoderIn,
  input  logic [6:0]            DecoderSeg,
  output logic [6:0]            Segments,
  output logic [DIGITS-1:0]     DigitEnable,
  output logic                  FrameStart
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST_COUNT = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END  = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] ONE_HOT0 = {{(DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  // With no blanking window the scan never leaves DRIVE, including out of reset.
  localparam phase_e PHASE_INIT = (BLANK_CYCLES == 0) ? PH_DRIVE : PH_BLANK;

  logic [CW-1:0]       count_q, count_d;
  logic [DW-1:0]       digit_q, digit_d;
  phase_e              phase_q, phase_d;
  logic [4*DIGITS-1:0] active_q, active_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   en_q, en_d;

  logic slot_end_s;
  logic frame_end_s;
  logic accept_s;
  logic lit_s;

  assign LoadReady   = ~pending_q & ~Reset;
  assign FrameStart  = ~Reset & (digit_q == {DW{1'b0}}) & (count_q == {CW{1'b0}});
  assign DecoderIn   = active_q[{digit_q, 2'b00} +: 4];
  assign Segments    = seg_q;
  assign DigitEnable = en_q;

  // Next-state: slot/digit scan, phase, load handshake, frame commit, pin drive.
  always_comb begin
    slot_end_s  = (count_q == LAST_COUNT);
    frame_end_s = slot_end_s & (digit_q == LAST_DIGIT);
    accept_s    = LoadValid & LoadReady;

    count_d = slot_end_s ? {CW{1'b0}} : count_q + {{(CW-1){1'b0}}, 1'b1};

    if (!slot_end_s) begin
      digit_d = digit_q;
    end else if (digit_q == LAST_DIGIT) begin
      digit_d = {DW{1'b0}};
    end else begin
      digit_d = digit_q + {{(DW-1){1'b0}}, 1'b1};
    end

    if (BLANK_CYCLES == 0) begin
      phase_d = PH_DRIVE;
    end else if (slot_end_s) begin
      phase_d = PH_BLANK;
    end else if (count_q == BLANK_END) begin
      phase_d = PH_DRIVE;
    end else begin
      phase_d = phase_q;
    end

    // Accept needs Pending=0 and commit needs Pending=1, so they never collide.
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (frame_end_s && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (accept_s) begin
      shadow_d  = LoadData;
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    lit_s = (phase_q == PH_DRIVE) & ~BlankMask[digit_q];
    if (lit_s) begin
      en_d  = ONE_HOT0 << digit_q;
      seg_d = DecoderSeg;
    end else begin
      en_d  = {DIGITS{1'b0}};
      seg_d = 7'b000_0000;
    end
  end

  // State and registered pin drive, with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q   <= {CW{1'b0}};
      digit_q   <= {DW{1'b0}};
      phase_q   <= PHASE_INIT;
      active_q  <= {(4*DIGITS){1'b0}};
      shadow_q  <= {(4*DIGITS){1'b0}};
      pending_q <= 1'b0;
      seg_q     <= 7'b000_0000;
      en_q      <= {DIGITS{1'b0}};
    end else begin
      count_q   <= count_d;
      digit_q   <= digit_d;
      phase_q   <= phase_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      en_q      <= en_d;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller (DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2)
// against a cycle-indexed reference model with an attached hex decoder.
module tb_display_scan_controller;

  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = ND * DIV;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        LoadValid;
  logic        LoadReady;
  logic [15:0] LoadData;
  logic [3:0]  BlankMask;
  logic [3:0]  DecoderIn;
  logic [6:0]  DecoderSeg;
  logic [6:0]  Segments;
  logic [3:0]  DigitEnable;
  logic        FrameStart;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: t = cycles into the scan since the last reset edge
  bit          known = 1'b0;
  int          t = 0;
  logic [15:0] m_active = 16'h0000;
  logic [15:0] m_shadow = 16'h0000;
  bit          m_pending = 1'b0;
  logic [6:0]  m_seg = 7'h00;
  logic [3:0]  m_en = 4'h0;

  always #5 Clock = ~Clock;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h7E; 4'h1: hex7 = 7'h30; 4'h2: hex7 = 7'h6D; 4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33; 4'h5: hex7 = 7'h5B; 4'h6: hex7 = 7'h5F; 4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F; 4'h9: hex7 = 7'h7B; 4'hA: hex7 = 7'h77; 4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E; 4'hD: hex7 = 7'h3D; 4'hE: hex7 = 7'h4F; 4'hF: hex7 = 7'h47;
      default: hex7 = 7'h00;
    endcase
  endfunction

  assign DecoderSeg = hex7(DecoderIn);

  display_scan_controller #(.DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
    .Clock(Clock), .Reset(Reset), .LoadValid(LoadValid), .LoadReady(LoadReady),
    .LoadData(LoadData), .BlankMask(BlankMask), .DecoderIn(DecoderIn),
    .DecoderSeg(DecoderSeg), .Segments(Segments), .DigitEnable(DigitEnable),
    .FrameStart(FrameStart)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check pins.
  task automatic run_cycle(input bit rst, input bit valid, input logic [15:0] data,
                           input logic [3:0] mask);
    int          digit;
    bit          lit;
    logic [15:0] act;
    Reset = rst; LoadValid = valid; LoadData = data; BlankMask = mask;
    #1;
    digit = (t / DIV) % ND;
    act   = m_active;
    if (known) begin
      check("LoadReady", {15'd0, LoadReady}, {15'd0, (!rst && !m_pending)});
      check("FrameStart", {15'd0, FrameStart}, {15'd0, (!rst && (t % FRAME) == 0)});
      check("DecoderIn", {12'd0, DecoderIn}, {12'd0, act[digit*4 +: 4]});
    end
    if (rst) begin
      known = 1'b1; t = 0;
      m_active = 16'h0000; m_shadow = 16'h0000; m_pending = 1'b0;
      m_en = 4'h0; m_seg = 7'h00;
    end else begin
      lit   = ((t % DIV) >= BLANK) && !mask[digit];
      m_en  = lit ? 4'(1 << digit) : 4'h0;
      m_seg = lit ? hex7(act[digit*4 +: 4]) : 7'h00;
      if (m_pending && (t % FRAME) == FRAME - 1) begin
        m_active = m_shadow; m_pending = 1'b0;
      end else if (valid && !m_pending) begin
        m_shadow = data; m_pending = 1'b1;
      end
      t++;
    end
    @(posedge Clock);
    #1;
    if (known) begin
      check("Segments", {9'd0, Segments}, {9'd0, m_seg});
      check("DigitEnable", {12'd0, DigitEnable}, {12'd0, m_en});
      check("OneHot", 16'($countones(DigitEnable) <= 1), 16'd1);
    end
  endtask

  initial begin
    logic [15:0] d;
    logic [3:0]  mk;
    Reset = 1'b1; LoadValid = 1'b0; LoadData = 16'h0000; BlankMask = 4'h0;
    // 1: power-up reset, run into mid-scan, reset 3 cycles, release
    repeat (2) run_cycle(1'b1, 1'b0, 16'h0000, 4'h0);
    repeat (13) run_cycle(1'b0, 1'b0, 16'h0000, 4'h0);
    repeat (3) run_cycle(1'b1, 1'b0, 16'h0000, 4'h0);
    check("RstSegments", {9'd0, Segments}, 16'd0);
    check("RstEnable", {12'd0, DigitEnable}, 16'd0);
    repeat (4) run_cycle(1'b0, 1'b0, 16'h0000, 4'h0);
    check("Digit0Lit", {12'd0, DigitEnable}, 16'h0001);
    check("Digit0Zero", {9'd0, Segments}, 16'h007E);
    // 2: mid-frame load of 1234, hold on display until frame end
    repeat (6) run_cycle(1'b0, 1'b0, 16'h0000, 4'h0);
    run_cycle(1'b0, 1'b1, 16'h1234, 4'h0);
    check("ReadyDropped", {15'd0, LoadReady}, 16'd0);
    // 3: second value offered while pending, held until accepted
    d = 16'($urandom);
    repeat (FRAME + 4) run_cycle(1'b0, 1'b1, d, 4'h0);
    // 4: mask digit 3 for two frames
    repeat (2 * FRAME) run_cycle(1'b0, 1'b0, 16'h0000, 4'b1000);
    // 5: free run three frames
    repeat (3 * FRAME) run_cycle(1'b0, 1'b0, 16'h0000, 4'h0);
    // randomized traffic: producer holds data while not ready
    d = 16'($urandom);
    for (int i = 0; i < 300; i++) begin
      if (!m_pending) d = 16'($urandom);
      mk = 4'($urandom_range(0, 15));
      if ((i % 50) < 25) mk = 4'h0;
      run_cycle(1'b0, 1'($urandom_range(0, 1)), d, mk);
    end
    // 6: make Pending=1, then reset coinciding with LoadValid
    while (m_pending) run_cycle(1'b0, 1'b0, 16'h0000, 4'h0);
    run_cycle(1'b0, 1'b1, 16'hBEEF, 4'h0);
    run_cycle(1'b1, 1'b1, 16'hCAFE, 4'h0);
    run_cycle(1'b1, 1'b1, 16'hCAFE, 4'h0);
    repeat (2 * FRAME + 2) run_cycle(1'b0, 1'b0, 16'h0000, 4'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
